// File: rtl/sp_pkg.sv
// sp_pkg: shared types and widths for the single-port load/store unit.
// Holds access-size and FSM-state encodings plus the alignment rule.
package sp_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

  // True when the access cannot be performed (misaligned or reserved size).
  function automatic logic req_bad(size_e sz, logic [1:0] off);
    logic bad;
    unique case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sp_lsu_align.sv
// sp_lsu_align: lane extract for loads and lane merge for stores.
// Purely combinational; word size passes data straight through.
module sp_lsu_align
  import sp_pkg::*;
(
  input  size_e                 size,
  input  logic [1:0]            offset,
  input  logic                  sgn,
  input  logic [DATA_WIDTH-1:0] rd_word,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic [DATA_WIDTH-1:0] mg_word
);

  logic [4:0]            sh;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] mask;

  assign sh   = {offset, 3'b000};
  assign lane = rd_word >> sh;

  // Select lane and byte mask by size, then splice the store data in.
  always_comb begin
    ld_data = rd_word;
    mask    = '1;
    unique case (size)
      SZ_BYTE: begin
        ld_data = {{24{sgn & lane[7]}}, lane[7:0]};
        mask    = 32'h0000_00ff << sh;
      end
      SZ_HALF: begin
        ld_data = {{16{sgn & lane[15]}}, lane[15:0]};
        mask    = 32'h0000_ffff << sh;
      end
      default: begin
        ld_data = rd_word;
        mask    = '1;
      end
    endcase
    mg_word = (rd_word & ~mask) | ((st_data << sh) & mask);
  end

endmodule

// File: rtl/sp_lsu.sv
// sp_lsu: single-outstanding load/store unit over a word memory.
// Sub-word stores do read-modify-write; errors skip memory entirely.
module sp_lsu
  import sp_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_signed_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  lsu_state_e            state_q;
  logic                  we_q;
  size_e                 size_q;
  logic                  sgn_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  size_e                 req_sz;
  logic                  bad;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] mg_word;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign req_sz    = size_e'(req_size_i);
  assign bad       = req_bad(req_sz, req_addr_i[1:0]);
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  sp_lsu_align u_align (
    .size    (size_q),
    .offset  (addr_q[1:0]),
    .sgn     (sgn_q),
    .rd_word (mem_rdata_i),
    .st_data (data_q),
    .ld_data (ld_data),
    .mg_word (mg_word)
  );

  // Request FSM: latch on accept, sequence memory access, pulse response.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            we_q    <= req_we_i;
            size_q  <= req_sz;
            sgn_q   <= req_signed_i;
            addr_q  <= req_addr_i;
            data_q  <= req_wdata_i;
            rdata_q <= '0;
            err_q   <= bad;
            if (bad)
              state_q <= ST_RESP;
            else if (!req_we_i)
              state_q <= ST_LOAD;
            else if (req_sz == SZ_WORD)
              state_q <= ST_WRITE;
            else
              state_q <= ST_RMW_RD;
          end
        end
        ST_LOAD: begin
          rdata_q <= ld_data;
          state_q <= ST_RESP;
        end
        ST_RMW_RD: begin
          data_q  <= mg_word;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = arst_ni && (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign mem_we_o    = (state_q == ST_WRITE);
  assign mem_waddr_o = word_addr;
  assign mem_raddr_o = word_addr;
  assign mem_wdata_o = data_q;

endmodule

// File: tb/tb_sp_lsu.sv
// tb_sp_lsu: directed plus randomized bench for sp_lsu.
// Byte-level reference memory predicts every cycle of the DUT outputs.
module tb_sp_lsu;
  import sp_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_signed_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_we_o;
  logic [31:0] mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_raddr_o;
  logic [31:0] mem_rdata_i;

  always #5 clk_i = ~clk_i;

  sp_lsu dut (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_size_i   (req_size_i),
    .req_signed_i (req_signed_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .mem_we_o     (mem_we_o),
    .mem_waddr_o  (mem_waddr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_raddr_o  (mem_raddr_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  assign mem_rdata_i = mem[widx(mem_raddr_o)];

  always @(posedge clk_i)
    if (mem_we_o) mem[widx(mem_waddr_o)] <= mem_wdata_o;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h t=%0t", nm, got, exp, $time);
    end
  endtask

  // reference model state
  bit          busy = 0;
  bit          acc = 0;
  int          cyc = 0;
  int          lat = 0;
  bit          m_wr, m_err, exp_v, exp_we;
  logic [31:0] m_rdata, m_word, m_addr, v;
  logic [7:0]  mb [4];
  int          n, off;
  int          we_cnt = 0;
  int          rsp_cnt = 0;

  always @(negedge clk_i) begin
    we_cnt  += int'(mem_we_o);
    rsp_cnt += int'(rsp_valid_o);
    if (!arst_ni) begin
      chk("rst_ready", 32'(req_ready_o), 0);
      chk("rst_valid", 32'(rsp_valid_o), 0);
      chk("rst_err", 32'(rsp_err_o), 0);
      chk("rst_rdata", rsp_rdata_o, 0);
      chk("rst_we", 32'(mem_we_o), 0);
      chk("rst_raddr", mem_raddr_o, 0);
      chk("rst_waddr", mem_waddr_o, 0);
      busy = 0;
      acc  = 0;
    end else begin
      exp_v  = busy && (cyc == lat);
      exp_we = busy && m_wr && (cyc == lat - 1);
      chk("ready", 32'(req_ready_o), 32'(!busy));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_v));
      chk("mem_we", 32'(mem_we_o), 32'(exp_we));
      chk("rsp_err", 32'(rsp_err_o), exp_v ? 32'(m_err) : 0);
      chk("rsp_rdata", rsp_rdata_o, exp_v ? m_rdata : 0);
      if (exp_we) begin
        chk("waddr", mem_waddr_o, m_addr & 32'hFFFF_FFFC);
        chk("wdata", mem_wdata_o, m_word);
        ref_mem[widx(m_addr)] = m_word;
      end
      acc = 0;
      if (busy) begin
        if (cyc == lat) busy = 0;
        else cyc++;
      end else if (req_valid_i) begin
        acc    = 1;
        busy   = 1;
        cyc    = 1;
        m_addr = req_addr_i;
        off    = int'(req_addr_i[1:0]);
        n      = 1 << int'(req_size_i);
        m_err  = (req_size_i == 2'd3) ||
                 (req_size_i == 2'd1 && (off % 2) != 0) ||
                 (req_size_i == 2'd2 && off != 0);
        m_wr   = req_we_i && !m_err;
        lat    = m_err ? 1 : (!req_we_i ? 2 : (req_size_i == 2'd2 ? 2 : 3));
        for (int i = 0; i < 4; i++)
          mb[i] = ref_mem[widx(m_addr)][8*i +: 8];
        v = 0;
        if (!m_err) begin
          for (int i = 0; i < n; i++) begin
            v = v | (32'(mb[off+i]) << (8 * i));
            if (req_we_i) mb[off+i] = req_wdata_i[8*i +: 8];
          end
          if (req_signed_i && n < 4 && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        end
        m_rdata = (m_err || req_we_i) ? 32'h0 : v;
        m_word  = {mb[3], mb[2], mb[1], mb[0]};
      end
    end
  end

  task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
    mem[widx(a)]     = d;
    ref_mem[widx(a)] = d;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int wc, output int lt,
                       output logic [31:0] rd, output logic er);
    req_we_i     = we;
    req_size_i   = sz;
    req_signed_i = sg;
    req_addr_i   = a;
    req_wdata_i  = wd;
    req_valid_i  = 1'b1;
    wc = 0;
    lt = 0;
    rd = 32'h0;
    er = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (acc) break;
      wc++;
      if (wc > 20) begin
        chk("accept_timeout", 32'(wc), 0);
        break;
      end
    end
    req_valid_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      lt++;
      if (rsp_valid_o) begin
        rd = rsp_rdata_o;
        er = rsp_err_o;
        break;
      end
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

  int          wc, lt, w0, r0, nreq, cy;
  logic [31:0] rd, tmp;
  logic        er;

  initial begin
    arst_ni      = 1'b0;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_size_i   = 2'd0;
    req_signed_i = 1'b0;
    req_addr_i   = 32'h0;
    req_wdata_i  = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      tmp = $urandom;
      mem[i] = tmp;
      ref_mem[i] = tmp;
    end
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_ready", 32'(req_ready_o), 0);
    chk("reset_we", 32'(mem_we_o), 0);
    arst_ni = 1'b1;

    bd_write(32'h400, 32'h8899AABB);
    issue(1'b0, 2'd0, 1'b1, 32'h403, 32'h0, wc, lt, rd, er);
    chk("lb_signed_data", rd, 32'hFFFF_FF88);
    chk("lb_signed_lat", 32'(lt), 2);
    issue(1'b0, 2'd0, 1'b0, 32'h403, 32'h0, wc, lt, rd, er);
    chk("lb_unsigned_data", rd, 32'h0000_0088);
    chk("lb_unsigned_err", 32'(er), 0);

    bd_write(32'h200, 32'h11223344);
    w0 = we_cnt;
    issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000BEEF, wc, lt, rd, er);
    chk("sh_mem", mem[widx(32'h200)], 32'hBEEF3344);
    chk("sh_lat", 32'(lt), 3);
    chk("sh_we_pulses", 32'(we_cnt - w0), 1);

    w0 = we_cnt;
    issue(1'b0, 2'd2, 1'b0, 32'h401, 32'h0, wc, lt, rd, er);
    chk("lw_mis_err", 32'(er), 1);
    chk("lw_mis_lat", 32'(lt), 1);
    chk("lw_mis_data", rd, 0);
    tmp = mem[widx(32'h404)];
    issue(1'b1, 2'd3, 1'b0, 32'h404, 32'h12345678, wc, lt, rd, er);
    chk("rsvd_err", 32'(er), 1);
    chk("rsvd_lat", 32'(lt), 1);
    chk("err_no_we", 32'(we_cnt - w0), 0);
    chk("err_mem400", mem[widx(32'h400)], 32'h8899AABB);
    chk("err_mem404", mem[widx(32'h404)], tmp);

    bd_write(32'h300, 32'h01020304);
    w0 = we_cnt;
    r0 = rsp_cnt;
    req_we_i    = 1'b1;
    req_size_i  = 2'd2;
    req_addr_i  = 32'h300;
    req_wdata_i = 32'hDEADBEEF;
    req_valid_i = 1'b1;
    wc = 0;
    forever begin
      @(posedge clk_i); #1;
      if (acc || wc > 20) break;
      wc++;
    end
    chk("abort_accept", 32'(wc), 0);
    arst_ni     = 1'b0;
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    arst_ni = 1'b1;
    chk("abort_no_we", 32'(we_cnt - w0), 0);
    chk("abort_no_rsp", 32'(rsp_cnt - r0), 0);
    chk("abort_mem", mem[widx(32'h300)], 32'h01020304);
    issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, wc, lt, rd, er);
    chk("first_accept_wait", 32'(wc), 0);
    chk("post_rst_load", rd, 32'h01020304);
    chk("post_rst_lat", 32'(lt), 2);

    nreq = 0;
    cy = 0;
    while (nreq < 5000 && cy < 80000) begin
      @(posedge clk_i); #1;
      cy++;
      if (acc) nreq++;
      if (!req_valid_i || acc) begin
        req_valid_i  = ($urandom_range(3) != 0);
        req_we_i     = 1'($urandom_range(1));
        req_size_i   = 2'($urandom_range(3));
        req_signed_i = 1'($urandom_range(1));
        req_addr_i   = $urandom & 32'hF;
        req_wdata_i  = $urandom;
      end
    end
    req_valid_i = 1'b0;
    chk("rand_requests", 32'(nreq), 5000);
    repeat (6) @(posedge clk_i);
    #1;
    for (int i = 0; i < 1024; i++)
      chk("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_lsu.md
SP_LSU -- requirements
Module: sp_lsu

Interface
REQ-001 Parameters: none; ADDR_WIDTH and DATA_WIDTH (32) SHALL come from sp_pkg.
REQ-002 clk_i  input  1  single clock; all state on its rising edge.
REQ-003 arst_ni  input  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  input  1  core access request valid.
REQ-005 req_ready_o  output  1  LSU accepts request this cycle.
REQ-006 req_we_i  input  1  1 = store, 0 = load.
REQ-007 req_size_i  input  2  access size (sp_pkg size_e: 0 byte, 1 half, 2 word, 3 reserved).
REQ-008 req_signed_i  input  1  sign-extend load result.
REQ-009 req_addr_i  input  ADDR_WIDTH  byte address.
REQ-010 req_wdata_i  input  32  store data, right-aligned.
REQ-011 rsp_valid_o  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata_o  output  32  load result, extended; 0 for stores/errors.
REQ-013 rsp_err_o  output  1  misaligned or reserved-size request.
REQ-014 mem_we_o, mem_waddr_o, mem_wdata_o  output  1/ADDR_WIDTH/32  memory write port.
REQ-015 mem_raddr_o  output  ADDR_WIDTH  memory read address; mem_rdata_i  input  32  combinational read data.

Function
REQ-016 Memory is word-addressed by addr[ADDR_WIDTH-1:2], little-endian, combinational read, write on clk_i edge with mem_we_o; LSU SHALL drive mem_waddr_o/mem_raddr_o with addr[1:0] forced to 0.
REQ-017 States: IDLE, LOAD, RMW_RD, WRITE, RESP.
REQ-018 IDLE: req_ready_o=1; on req_valid_i&req_ready_o, latch all req_* fields.
REQ-019 Error: half with addr[0]=1, word with addr[1:0]!=0, or size 3 -> RESP with rsp_err_o=1, no memory access.
REQ-020 Load -> LOAD; LOAD captures lane data from mem_rdata_i -> RESP.
REQ-021 Word store -> WRITE; sub-word store -> RMW_RD, which reads the word, merges byte/half into lane addr[1:0], -> WRITE.
REQ-022 WRITE: mem_we_o=1 for exactly one cycle with final data -> RESP.
REQ-023 RESP: rsp_valid_o=1 for one cycle -> IDLE; req_ready_o=0 in every non-IDLE state (no back-to-back overlap).
REQ-024 Latency accept-to-rsp_valid_o: error 1, load 2, word store 2, sub-word store 3 cycles.
REQ-025 Loads: byte/half zero- or sign-extended per req_signed_i; word passed as-is.
REQ-026 Sub-word store preserves all other bytes of the word bit-exactly, including X-free bytes only as read.
REQ-027 mem_we_o SHALL be 0 in every state except WRITE.
REQ-028 rsp_rdata_o and rsp_err_o SHALL be 0 whenever rsp_valid_o=0.

Reset
REQ-029 arst_ni low: state=IDLE, latched fields cleared, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, mem_we_o=0, addresses 0, req_ready_o=0 while arst_ni low.
REQ-030 Reset asserted mid-operation aborts it immediately: no memory write, no response, even in WRITE.
REQ-031 First acceptance possible in the first cycle after arst_ni deasserts.

Structure
REQ-032 sp_pkg SHALL hold size_e and lsu_state_e typedefs.
REQ-033 Lane extract/merge logic SHALL be one combinational sub-module sp_lsu_align (size, offset, signed, word in, data in -> extracted load, merged word).

Verification (bench uses r2_w1_32b_memory_model on mem ports, backdoor write/read)
REQ-034 Backdoor 0x400=0x8899AABB; load byte signed addr 0x403 -> rsp_rdata_o=0xFFFFFF88 in 2nd cycle; unsigned -> 0x00000088.
REQ-035 Backdoor 0x200=0x11223344; store half 0xBEEF at 0x202 -> backdoor read 0xBEEF3344 word, rsp_valid_o 3rd cycle, one mem_we_o pulse.
REQ-036 Load word 0x401 and store size 3 -> rsp_err_o=1 next cycle, mem_we_o never high, memory unchanged.
REQ-037 Reset asserted while in WRITE of word store 0xDEADBEEF to 0x300 -> backdoor read 0x300 unchanged, no rsp_valid_o.
REQ-038 5000 random requests (addr & 0xF, random valid/size/signed) vs reference memory: zero mismatches, req_ready_o low in all busy cycles.
